// File: rtl/iic_addrgen_param.sv
// IIC EEPROM word-address generator: serial capture of the 1..N-byte word address,
// then page-wrapping write increments and full roll-over read increments.
`timescale 1ns/1ps
module iic_addrgen_param #(
    parameter int ADDR_W     = 16,
    parameter int ADDR_BYTES = 2,
    parameter int PAGE_W     = 6,
    parameter int ECC_GRAN_W = 2
) (
    input  logic              iic_clk_c,
    input  logic              iic_sys_rst_n,
    input  logic              iic_frm_rst_n,
    input  logic              sda_in,
    input  logic              iic_addr_start,
    input  logic              iic_bit_vld,
    input  logic              iic_wr_byte_done,
    input  logic              iic_rd_byte_done,
    input  logic              iic_ecc_en,
    input  logic              iic_addr_keep,
    output logic [ADDR_W-1:0] iic_curr_addr,
    output logic              iic_addr_vld,
    output logic              iic_page_wrap,
    output logic              iic_ecc_word_end
);
    localparam int SH_W  = 8 * ADDR_BYTES;
    localparam int CNT_W = $clog2(SH_W);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SH_W - 1);
    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((64'(1) << PAGE_W) - 64'(1));
    localparam logic [ADDR_W-1:0] ECC_MASK  = ADDR_W'((64'(1) << ECC_GRAN_W) - 64'(1));

    typedef enum logic [1:0] {A_IDLE, A_RX, A_HOLD} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SH_W-1:0]   shift_q;
    logic [SH_W-1:0]   shift_d;
    logic              addr_vld_q;
    logic [ADDR_W-1:0] curr_addr_q, curr_addr_d;
    logic              page_wrap_q, page_wrap_d;
    logic              ecc_word_end_q, ecc_word_end_d;
    logic              frm_rst_n;
    logic              last_bit;
    logic              unused_shift_msb;

    // Frame reset only reaches the reception state; the address survives it.
    assign frm_rst_n        = iic_sys_rst_n & iic_frm_rst_n;
    assign shift_d          = {shift_q[SH_W-2:0], sda_in};
    assign unused_shift_msb = shift_q[SH_W-1];
    assign last_bit         = (state_q == A_RX) && iic_bit_vld && !iic_addr_start
                              && (cnt_q == LAST_CNT);

    always_comb begin
        curr_addr_d = curr_addr_q;
        page_wrap_d = 1'b0;
        if (last_bit) begin
            curr_addr_d = shift_d[ADDR_W-1:0];
            if (iic_ecc_en)
                curr_addr_d = shift_d[ADDR_W-1:0] & ~ECC_MASK;
        end else if (!iic_addr_start && !iic_addr_keep) begin
            // A write strobe always shadows a read strobe in the same cycle.
            if (iic_wr_byte_done) begin
                if (state_q == A_HOLD) begin
                    curr_addr_d = (curr_addr_q & ~PAGE_MASK)
                                | ((curr_addr_q + ADDR_W'(1)) & PAGE_MASK);
                    page_wrap_d = ((curr_addr_q & PAGE_MASK) == PAGE_MASK);
                end
            end else if (iic_rd_byte_done && (state_q != A_RX)) begin
                curr_addr_d = curr_addr_q + ADDR_W'(1);
            end
        end
        ecc_word_end_d = iic_ecc_en & (&curr_addr_d[ECC_GRAN_W-1:0]);
    end

    always_ff @(posedge iic_clk_c or negedge iic_sys_rst_n) begin
        if (!iic_sys_rst_n) begin
            curr_addr_q    <= '0;
            page_wrap_q    <= 1'b0;
            ecc_word_end_q <= 1'b0;
        end else begin
            curr_addr_q    <= curr_addr_d;
            page_wrap_q    <= page_wrap_d;
            ecc_word_end_q <= ecc_word_end_d;
        end
    end

    always_ff @(posedge iic_clk_c or negedge frm_rst_n) begin
        if (!frm_rst_n) begin
            state_q    <= A_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            addr_vld_q <= 1'b0;
        end else if (iic_addr_start) begin
            state_q    <= A_RX;
            cnt_q      <= '0;
            shift_q    <= '0;
            addr_vld_q <= 1'b0;
        end else if ((state_q == A_RX) && iic_bit_vld) begin
            shift_q <= shift_d;
            if (cnt_q == LAST_CNT) begin
                state_q    <= A_HOLD;
                cnt_q      <= '0;
                addr_vld_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign iic_curr_addr    = curr_addr_q;
    assign iic_addr_vld     = addr_vld_q;
    assign iic_page_wrap    = page_wrap_q;
    assign iic_ecc_word_end = ecc_word_end_q;

endmodule

// File: doc/iic_addrgen_param.md
Name: iic_addrgen_param

Overview:
Parametrised word-address generator for the IIC EEPROM slave. It captures a 1..N-byte word address serially from SDA after the write-direction command byte, and holds the current memory address. It advances the address with page-wrap on writes and full-array roll-over on reads, with optional ECC-word alignment. It sits between the IIC protocol FSM (which supplies bit/byte strobes) and the memory array/ECC datapath.

Parameters:
ADDR_W, 16, width of iic_curr_addr; 1..8*ADDR_BYTES.
ADDR_BYTES, 2, number of address bytes received per frame; 1..4.
PAGE_W, 6, log2 of write page size in bytes (64 B); 1..ADDR_W.
ECC_GRAN_W, 2, log2 of ECC word size in bytes (4 B); 1..PAGE_W.

Ports:
iic_clk_c  in  1  IIC-domain clock.
iic_sys_rst_n  in  1  asynchronous, active-low system reset.
iic_frm_rst_n  in  1  asynchronous active-low frame reset (START/STOP); clears FSM, bit counter and shift register only.
sda_in  in  1  sampled SDA level.
iic_addr_start  in  1  single-cycle pulse: write-direction command byte ACKed; address bytes follow.
iic_bit_vld  in  1  single-cycle strobe: sda_in holds a valid data bit.
iic_wr_byte_done  in  1  pulse: write data byte ACKed by slave.
iic_rd_byte_done  in  1  pulse: read data byte transferred to master.
iic_ecc_en  in  1  ECC mode enable (static within a frame).
iic_addr_keep  in  1  suppress any address increment this cycle.
iic_curr_addr  out  ADDR_W  current memory address.
iic_addr_vld  out  1  a complete address was received in this frame.
iic_page_wrap  out  1  single-cycle pulse: write increment wrapped within the page.
iic_ecc_word_end  out  1  current address is the last byte of an ECC word.

Behaviour:
- Clock iic_clk_c; reset iic_sys_rst_n, asynchronous, active-low. Reset values: iic_curr_addr=0, iic_addr_vld=0, iic_page_wrap=0, FSM=A_IDLE, bit counter=0, shift register=0.
- iic_sys_rst_n clears everything. iic_frm_rst_n clears FSM, bit counter and shift register, and forces iic_addr_vld=0. It leaves iic_curr_addr untouched so that a current-address read works.
- FSM states: A_IDLE, A_RX, A_HOLD.
  - A_IDLE/A_HOLD + iic_addr_start -> A_RX. Clears the counter and shift register, and clears iic_addr_vld.
  - A_RX: each iic_bit_vld shifts sda_in MSB-first into a register 8*ADDR_BYTES wide and increments the counter.
  - On the bit-vld with counter=8*ADDR_BYTES-1 -> A_HOLD. On the same edge, iic_curr_addr <= {shifted}[ADDR_W-1:0] and iic_addr_vld <= 1. The address is visible the cycle after the final bit. Bits above ADDR_W are discarded.
  - iic_addr_start while in A_RX restarts reception.
- ECC alignment: if iic_ecc_en=1 at load, the loaded address has its low ECC_GRAN_W bits forced to 0.
- Increment rules (when iic_addr_keep=0):
  - iic_wr_byte_done in A_HOLD: the low PAGE_W bits increment modulo 2^PAGE_W and the upper bits are held. iic_page_wrap=1 for one cycle when the low field goes from all-ones to 0.
  - iic_wr_byte_done in A_IDLE or A_RX is ignored.
  - iic_rd_byte_done in any state except A_RX: the full ADDR_W increments modulo 2^ADDR_W, i.e. 2^ADDR_W-1 -> 0. iic_page_wrap is not asserted.
  - iic_addr_keep=1 blocks both increments. Loading is not blocked.
- Priority, highest first: iic_addr_start / address load > iic_wr_byte_done > iic_rd_byte_done. If both done strobes fire in the same cycle, only the write increment is applied.
- iic_bit_vld outside A_RX is ignored. Done strobes during A_RX are ignored.
- iic_ecc_word_end = iic_ecc_en & (&iic_curr_addr[ECC_GRAN_W-1:0]). It is registered alongside iic_curr_addr (0 at reset).
- A frame reset in mid-A_RX discards the partial address. iic_curr_addr keeps its last loaded/incremented value.

Test Plan:
1. Defaults, ecc_en=0: addr_start, then 16 bits 0x12,0xC5 -> iic_curr_addr=0x12C5 and iic_addr_vld=1 one cycle after the 16th bit-vld.
2. Load 0x12FF, then iic_wr_byte_done -> 0x12C0 with a one-cycle iic_page_wrap pulse; a further write -> 0x12C1 with no pulse.
3. Load 0xFFFE, then 2x iic_rd_byte_done -> 0xFFFF, then 0x0000; iic_page_wrap stays 0. Also: wr and rd done in the same cycle from 0x0010 -> 0x0011 exactly once.
4. ecc_en=1: load 0x12C7 -> 0x12C4. 3x rd_done -> 0x12C7 with iic_ecc_word_end=1; 1 more rd_done -> 0x12C8 with iic_ecc_word_end=0.
5. iic_addr_keep=1 during 3 wr_done and 2 rd_done at 0x0040 -> iic_curr_addr stays 0x0040.
6. After loading 0x1234: addr_start, 9 bits, then iic_frm_rst_n pulse -> A_IDLE, iic_addr_vld=0, iic_curr_addr=0x1234. A following rd_done -> 0x1235, and a new 16-bit reception of 0xABCD loads 0xABCD.
